// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// Holds the controller state encoding and the default operand width.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit combinational full adder: the whole per-bit datapath of the
// serial adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: {cout,sum} = a + b + cin, one bit per clock, LSB first.
// Optional feature macro SERIAL_ADDER_OVF_EN adds a registered signed
// overflow flag (ovf) held alongside sum/cout.
//
// Handshake: start is accepted on a rising edge only while the FSM is in
// IDLE or DONE (i.e. busy is low); a, b and cin are sampled on that same
// edge. busy is high for exactly WIDTH cycles while the bits are being
// computed, then done pulses for one cycle with sum/cout valid. Holding
// start high during the done cycle launches the next addition back-to-back.
// start while busy is ignored. sum/cout keep their value until the next
// accepted addition completes.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  // One extra bit keeps the counter wide enough for any WIDTH in range.
  localparam int            CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] s_sr;
  logic             carry;
  logic             fa_sum;
  logic             fa_cout;
  logic             accept;
  logic             last_bit;

  full_adder u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  assign accept   = start && ((state == IDLE) || (state == DONE));
  assign last_bit = (state == RUN) && (cnt == LAST);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; busy/done decode directly from the state.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand/sum shift registers, carry flop and bit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr  <= '0;
      b_sr  <= '0;
      s_sr  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else if (accept) begin
      a_sr  <= a;
      b_sr  <= b;
      s_sr  <= '0;
      carry <= cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      s_sr  <= {fa_sum, s_sr[WIDTH-1:1]};
      carry <= fa_cout;
      cnt   <= cnt + CW'(1);
    end
  end

  // Result registers load only on the edge that enters DONE, so the
  // previous result stays visible throughout the next run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum  <= '0;
      cout <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf  <= 1'b0;
`endif
    end else if (last_bit) begin
      sum  <= {fa_sum, s_sr[WIDTH-1:1]};
      cout <= fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
      // carry is the carry into the MSB during the last bit.
      ovf  <= carry ^ fa_cout;
`endif
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed testbench for serial_adder at WIDTH=8 and WIDTH=16.
// Inputs are driven 1 time unit after a rising edge; outputs are sampled
// on the falling edge.
module tb_serial_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        cin8 = 1'b0;
  logic        busy8, done8, cout8;
  logic [7:0]  sum8;

  logic        start16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        cin16 = 1'b0;
  logic        busy16, done16, cout16;
  logic [15:0] sum16;

`ifdef SERIAL_ADDER_OVF_EN
  logic        ovf8, ovf16;
`endif

  int total = 0;
  int bad   = 0;
  bit both8 = 1'b0;
  bit both16 = 1'b0;

  // Clock and reset.
  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .cin(cin16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf16)
`endif
  );

  // ---------------- driver tasks ----------------
  // Raise start with operands just after the next rising edge.
  task automatic start_op8(input logic [7:0] a, input logic [7:0] b, input logic c);
    @(posedge clk);
    #1 start8 = 1'b1; a8 = a; b8 = b; cin8 = c;
  endtask

  task automatic start_op16(input logic [15:0] a, input logic [15:0] b, input logic c);
    @(posedge clk);
    #1 start16 = 1'b1; a16 = a; b16 = b; cin16 = c;
  endtask

  // Drops start after one edge, counts edges until done (bounded) and the
  // number of sampled busy cycles along the way.
  task automatic wait_done8(output int n, output int nb);
    n = 0; nb = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); n++;
      #1 start8 = 1'b0;
      @(negedge clk);
      if (busy8) nb++;
      if (busy8 && done8) both8 = 1'b1;
      if (done8) break;
    end
  endtask

  task automatic wait_done16(output int n, output int nb);
    n = 0; nb = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); n++;
      #1 start16 = 1'b0;
      @(negedge clk);
      if (busy16) nb++;
      if (busy16 && done16) both16 = 1'b1;
      if (done16) break;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL reset_busy8: got %b want 0", busy8); end
    total++; if (done8 !== 1'b0) begin bad++; $display("FAIL reset_done8: got %b want 0", done8); end
    total++; if (sum8 !== 8'h00) begin bad++; $display("FAIL reset_sum8: got %h want 00", sum8); end
    total++; if (cout8 !== 1'b0) begin bad++; $display("FAIL reset_cout8: got %b want 0", cout8); end
    total++; if (sum16 !== 16'h0000 || busy16 !== 1'b0 || done16 !== 1'b0) begin
      bad++; $display("FAIL reset_dut16: got sum=%h busy=%b done=%b want 0/0/0", sum16, busy16, done16); end
`ifdef SERIAL_ADDER_OVF_EN
    total++; if (ovf8 !== 1'b0) begin bad++; $display("FAIL reset_ovf8: got %b want 0", ovf8); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_zero;
    int n, nb;
    start_op8(8'h00, 8'h00, 1'b0);
    wait_done8(n, nb);
    total++; if (n != 9) begin bad++; $display("FAIL zero_latency: got %0d want 9", n); end
    total++; if (nb != 8) begin bad++; $display("FAIL zero_busy_cycles: got %0d want 8", nb); end
    total++; if (sum8 !== 8'h00 || cout8 !== 1'b0) begin
      bad++; $display("FAIL zero_result: got %b_%h want 0_00", cout8, sum8); end
    @(negedge clk);
    total++; if (done8 !== 1'b0 || busy8 !== 1'b0) begin
      bad++; $display("FAIL zero_done_pulse: got done=%b busy=%b want 0/0", done8, busy8); end
  endtask

  task automatic test_arith;
    int n, nb;
    logic [7:0] av [5] = '{8'hFF, 8'hA5, 8'h12, 8'h80, 8'h3C};
    logic [7:0] bv [5] = '{8'h01, 8'h5A, 8'h34, 8'h7F, 8'h0F};
    logic       cv [5] = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b1};
    logic [8:0] ev [5] = '{9'h100, 9'h100, 9'h046, 9'h100, 9'h04C};
    for (int i = 0; i < 5; i++) begin
      start_op8(av[i], bv[i], cv[i]);
      wait_done8(n, nb);
      total++; if ({cout8, sum8} !== ev[i] || n != 9) begin
        bad++; $display("FAIL arith_%0d: got %b_%h after %0d want %b_%h after 9",
                        i, cout8, sum8, n, ev[i][8], ev[i][7:0]); end
    end
  endtask

  task automatic test_hold;
    int n, nb;
    start_op8(8'h12, 8'h34, 1'b0);
    wait_done8(n, nb);
    start_op8(8'hC8, 8'h64, 1'b0);
    @(posedge clk); #1 start8 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (sum8 !== 8'h46 || busy8 !== 1'b1) begin
      bad++; $display("FAIL hold_during_run: got sum=%h busy=%b want 46/1", sum8, busy8); end
    wait_done8(n, nb);
    total++; if (sum8 !== 8'h2C || cout8 !== 1'b1) begin
      bad++; $display("FAIL hold_result: got %b_%h want 1_2c", cout8, sum8); end
  endtask

  task automatic test_ignore_start;
    int ndone = 0;
    int first = 0;
    start_op8(8'h01, 8'h01, 1'b0);
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) start8 = 1'b0;
      if (i == 3) begin start8 = 1'b1; a8 = 8'hF0; b8 = 8'h0F; end
      if (i == 4) start8 = 1'b0;
      @(negedge clk);
      if (done8) begin ndone++; if (first == 0) first = i; end
    end
    total++; if (ndone != 1) begin bad++; $display("FAIL ignore_done_count: got %0d want 1", ndone); end
    total++; if (first != 9) begin bad++; $display("FAIL ignore_latency: got %0d want 9", first); end
    total++; if (sum8 !== 8'h02 || cout8 !== 1'b0) begin
      bad++; $display("FAIL ignore_result: got %b_%h want 0_02", cout8, sum8); end
  endtask

  task automatic test_reset_mid_run;
    int n, nb;
    int ndone = 0;
    start_op8(8'h55, 8'h11, 1'b0);
    @(posedge clk); #1 start8 = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (busy8 !== 1'b0 || done8 !== 1'b0) begin
      bad++; $display("FAIL rstrun_ctrl: got busy=%b done=%b want 0/0", busy8, done8); end
    total++; if (sum8 !== 8'h00 || cout8 !== 1'b0) begin
      bad++; $display("FAIL rstrun_sum: got %b_%h want 0_00", cout8, sum8); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done8 || busy8) ndone++;
    end
    total++; if (ndone != 0) begin bad++; $display("FAIL rstrun_no_done: got %0d active cycles want 0", ndone); end
    start_op8(8'h03, 8'h04, 1'b0);
    wait_done8(n, nb);
    total++; if (sum8 !== 8'h07 || n != 9) begin
      bad++; $display("FAIL rstrun_restart: got %h after %0d want 07 after 9", sum8, n); end
  endtask

  task automatic test_back_to_back;
    int n, nb;
    start_op8(8'h01, 8'h02, 1'b0);
    wait_done8(n, nb);
    total++; if (sum8 !== 8'h03) begin bad++; $display("FAIL b2b8_first: got %h want 03", sum8); end
    start8 = 1'b1; a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0;
    wait_done8(n, nb);
    total++; if (n != 9) begin bad++; $display("FAIL b2b8_gap: got %0d want 9", n); end
    total++; if (sum8 !== 8'h30 || cout8 !== 1'b0) begin
      bad++; $display("FAIL b2b8_second: got %b_%h want 0_30", cout8, sum8); end
    @(negedge clk);
    total++; if (done8 !== 1'b0 || busy8 !== 1'b0) begin
      bad++; $display("FAIL b2b8_idle: got done=%b busy=%b want 0/0", done8, busy8); end
  endtask

  task automatic test_wide;
    int n, nb;
    start_op16(16'hFFFF, 16'h0001, 1'b0);
    wait_done16(n, nb);
    total++; if (n != 17 || nb != 16) begin
      bad++; $display("FAIL wide_latency: got %0d/%0d want 17/16", n, nb); end
    total++; if (sum16 !== 16'h0000 || cout16 !== 1'b1) begin
      bad++; $display("FAIL wide_carry: got %b_%h want 1_0000", cout16, sum16); end
    start_op16(16'h1234, 16'h1111, 1'b1);
    wait_done16(n, nb);
    total++; if (sum16 !== 16'h2346 || cout16 !== 1'b0) begin
      bad++; $display("FAIL wide_first: got %b_%h want 0_2346", cout16, sum16); end
    start16 = 1'b1; a16 = 16'h0010; b16 = 16'h0020; cin16 = 1'b0;
    wait_done16(n, nb);
    total++; if (n != 17 || sum16 !== 16'h0030) begin
      bad++; $display("FAIL wide_b2b: got %h after %0d want 0030 after 17", sum16, n); end
  endtask

`ifdef SERIAL_ADDER_OVF_EN
  task automatic test_ovf;
    int n, nb;
    start_op8(8'h7F, 8'h01, 1'b0);
    wait_done8(n, nb);
    total++; if (sum8 !== 8'h80 || ovf8 !== 1'b1 || cout8 !== 1'b0) begin
      bad++; $display("FAIL ovf_pos: got sum=%h ovf=%b cout=%b want 80/1/0", sum8, ovf8, cout8); end
    start_op8(8'h80, 8'h80, 1'b0);
    wait_done8(n, nb);
    total++; if (sum8 !== 8'h00 || ovf8 !== 1'b1 || cout8 !== 1'b1) begin
      bad++; $display("FAIL ovf_neg: got sum=%h ovf=%b cout=%b want 00/1/1", sum8, ovf8, cout8); end
    start_op8(8'hFF, 8'h01, 1'b0);
    wait_done8(n, nb);
    total++; if (sum8 !== 8'h00 || ovf8 !== 1'b0 || cout8 !== 1'b1) begin
      bad++; $display("FAIL ovf_none: got sum=%h ovf=%b cout=%b want 00/0/1", sum8, ovf8, cout8); end
  endtask
`endif

  task automatic test_exclusive;
    total++; if (both8 || both16) begin
      bad++; $display("FAIL busy_done_overlap: got %b/%b want 0/0", both8, both16); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset;
    test_zero;
    test_arith;
    test_hold;
    test_ignore_start;
    test_reset_mid_run;
    test_back_to_back;
    test_wide;
`ifdef SERIAL_ADDER_OVF_EN
    test_ovf;
`endif
    test_exclusive;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
